// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Frame layout: {stop, odd parity, data[7:0]}, shifted LSB first.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NAK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int FRAME_BITS = 10;

  function automatic logic [FRAME_BITS-1:0] mk_frame(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchronizer for one PS/2 line with a falling-edge pulse.
// Flops reset to 1 so an idle bus never produces a spurious edge.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device transmit sequencer: inhibit, RTS, shift, ACK check.
// Drives active-high pull-low tx lines; all outputs are registered.
module ps2_host_tx_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code,
  input  logic       ps2_clk_rx,
  input  logic       ps2_d_rx,
  output logic       ps2_clk_tx,
  output logic       ps2_d_tx
);

  localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                        TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(FRAME_BITS);

  ps2_state_e            state_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [TW-1:0]         timer_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  nak_q;
  logic                  clk_tx_q, d_tx_q;
  logic                  ready_q, busy_q;
  logic                  done_q, err_q;
  logic [1:0]            code_q;

  logic clk_s, clk_fall;
  logic [SYNC_STAGES-1:0] dsync_q;
  logic d_s;
  logic tmo;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (ps2_clk_rx),
    .q_o    (clk_s),
    .fall_o (clk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsync_q <= '1;
    end else begin
      dsync_q[0] <= ps2_d_rx;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dsync_q[i] <= dsync_q[i-1];
      end
    end
  end

  assign d_s = dsync_q[SYNC_STAGES-1];

  assign tmo = (state_q == SHIFT || state_q == ACK ||
                state_q == WAIT_IDLE) && (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      nak_q     <= 1'b0;
      clk_tx_q  <= 1'b0;
      d_tx_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // A stalled device wins over any edge seen in the same cycle
      if (tmo) begin
        clk_tx_q <= 1'b0;
        d_tx_q   <= 1'b0;
        code_q   <= ERR_TIMEOUT;
        done_q   <= 1'b1;
        err_q    <= 1'b1;
        busy_q   <= 1'b0;
        state_q  <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (tx_valid && ready_q) begin
              frame_q  <= mk_frame(tx_data);
              code_q   <= ERR_NONE;
              nak_q    <= 1'b0;
              clk_tx_q <= 1'b1;
              timer_q  <= TW'(INHIBIT_CYCLES);
              ready_q  <= 1'b0;
              busy_q   <= 1'b1;
              state_q  <= INHIBIT;
            end else begin
              ready_q <= 1'b1;
            end
          end
          INHIBIT: begin
            if (timer_q == '0) begin
              d_tx_q  <= 1'b1;
              state_q <= START;
            end else begin
              timer_q <= timer_q - TW'(1);
            end
          end
          START: begin
            clk_tx_q  <= 1'b0;
            timer_q   <= TW'(TIMEOUT_CYCLES);
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
          SHIFT: begin
            timer_q <= timer_q - TW'(1);
            if (clk_fall) begin
              d_tx_q <= ~frame_q[bit_cnt_q];
              if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                state_q <= ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
            end
          end
          ACK: begin
            timer_q <= timer_q - TW'(1);
            if (clk_fall) begin
              if (d_s) begin
                nak_q  <= 1'b1;
                code_q <= ERR_NAK;
              end
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            timer_q <= timer_q - TW'(1);
            if (clk_s && d_s) begin
              done_q  <= 1'b1;
              err_q   <= nak_q;
              state_q <= DONE;
            end
          end
          DONE: begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign tx_err_code = code_q;
  assign ps2_clk_tx  = clk_tx_q;
  assign ps2_d_tx    = d_tx_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl: open-drain bus plus a behavioural device
// that clocks frames, captures bits and answers with ACK or NAK.
module tb_ps2_host_tx_ctrl;

  localparam int INH  = 20;
  localparam int TMO  = 5000;
  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] tx_err_code;
  logic       ps2_clk_tx, ps2_d_tx;
  logic       dev_clk_low, dev_d_low;
  logic       clk_line, d_line;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  int         done_cnt = 0;
  logic       last_err;
  logic [1:0] last_code;
  logic       last_ct, last_dt;
  int         last_dc;

  logic [7:0] cap;
  logic       par, stp;
  int         hi, rel;
  bit         gd;

  logic [7:0] acc_q[$];
  int         acc_c[$];

  always #5 clk = ~clk;

  assign clk_line = ~(ps2_clk_tx | dev_clk_low);
  assign d_line   = ~(ps2_d_tx | dev_d_low);

  ps2_host_tx_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_err_code (tx_err_code),
    .ps2_clk_rx  (clk_line),
    .ps2_d_rx    (d_line),
    .ps2_clk_tx  (ps2_clk_tx),
    .ps2_d_tx    (ps2_d_tx)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && tx_done) begin
      done_cnt  <= done_cnt + 1;
      last_err  <= tx_err;
      last_code <= tx_err_code;
      last_ct   <= ps2_clk_tx;
      last_dt   <= ps2_d_tx;
      last_dc   <= cyc;
    end
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // Device side of one frame, starting while the host inhibits.
  task automatic device(input bit nak, input int np, input bit wdone,
                        output logic [7:0] c, output logic p,
                        output logic s, output int h, output int r,
                        output bit g_done);
    int g;
    int dn0;
    logic [9:0] bits;
    dn0  = done_cnt;
    h    = 0;
    g    = 0;
    bits = '1;
    while (ps2_d_tx !== 1'b1 && g < 2000) begin
      if (ps2_clk_tx) h++;
      @(negedge clk);
      g++;
    end
    g = 0;
    while (ps2_clk_tx !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    r = cyc;
    repeat (40) @(negedge clk);
    for (int k = 0; k < np; k++) begin
      if (k == 10 && !nak) dev_d_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k < 10) bits[k] = d_line;
      dev_clk_low = 1'b0;
      if (k == 10) dev_d_low = 1'b0;
    end
    g = 0;
    while (wdone && done_cnt == dn0 && g < 8000) begin
      @(negedge clk);
      g++;
    end
    g_done = (done_cnt != dn0);
    c = bits[7:0];
    p = bits[8];
    s = bits[9];
  endtask

  task automatic xfer(input logic [7:0] b, input bit nak, input int np);
    int g;
    g = 0;
    @(negedge clk);
    while (!tx_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    device(nak, np, 1'b1, cap, par, stp, hi, rel, gd);
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({tx_ready, tx_busy, tx_done, tx_err} !== 4'b1000)
      $display("FAIL reset_hs got %b want 1000",
               {tx_ready, tx_busy, tx_done, tx_err});
    else pass_cnt++;
    chk_cnt++;
    if (tx_err_code !== 2'b00)
      $display("FAIL reset_code got %b want 00", tx_err_code);
    else pass_cnt++;
    chk_cnt++;
    if ({ps2_clk_tx, ps2_d_tx} !== 2'b00)
      $display("FAIL reset_lines got %b want 00", {ps2_clk_tx, ps2_d_tx});
    else pass_cnt++;
  endtask

  task automatic test_f4();
    xfer(8'hF4, 1'b0, 11);
    chk_cnt++;
    if (hi !== INH + 1)
      $display("FAIL f4_inhibit got %0d want %0d", hi, INH + 1);
    else pass_cnt++;
    chk_cnt++;
    if ({stp, par, cap} !== {1'b1, 1'b0, 8'hF4})
      $display("FAIL f4_frame got %b want %b",
               {stp, par, cap}, {1'b1, 1'b0, 8'hF4});
    else pass_cnt++;
    chk_cnt++;
    if ({gd, last_err, last_code} !== 4'b1000)
      $display("FAIL f4_done got %b want 1000", {gd, last_err, last_code});
    else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [7:0] v[3];
    v[0] = 8'h00;
    v[1] = 8'hFF;
    v[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      xfer(v[i], 1'b0, 11);
      chk_cnt++;
      if ({stp, par, cap} !== {1'b1, odd_par(v[i]), v[i]})
        $display("FAIL parity_%02h got %b want %b", v[i],
                 {stp, par, cap}, {1'b1, odd_par(v[i]), v[i]});
      else pass_cnt++;
      chk_cnt++;
      if ({gd, last_err, last_code} !== 4'b1000)
        $display("FAIL parity_done_%02h got %b want 1000", v[i],
                 {gd, last_err, last_code});
      else pass_cnt++;
    end
  endtask

  task automatic test_nak();
    xfer(8'hED, 1'b1, 11);
    chk_cnt++;
    if ({gd, last_err, last_code} !== 4'b1101)
      $display("FAIL nak_done got %b want 1101", {gd, last_err, last_code});
    else pass_cnt++;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if ({tx_ready, tx_busy, tx_err_code} !== 4'b1001)
      $display("FAIL nak_idle got %b want 1001",
               {tx_ready, tx_busy, tx_err_code});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int dt;
    xfer(8'($urandom), 1'b0, 4);
    dt = last_dc - rel;
    chk_cnt++;
    if (!gd || dt < TMO || dt > TMO + 1)
      $display("FAIL tmo_time got done=%0d after %0d want %0d..%0d",
               gd, dt, TMO, TMO + 1);
    else pass_cnt++;
    chk_cnt++;
    if ({last_ct, last_dt, last_err, last_code} !== 5'b00110)
      $display("FAIL tmo_out got %b want 00110",
               {last_ct, last_dt, last_err, last_code});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int g;
    g = 0;
    @(negedge clk);
    while (!tx_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    device(1'b0, 2, 1'b0, cap, par, stp, hi, rel, gd);
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (ps2_d_tx !== 1'b1)
      $display("FAIL rst_pre got %b want 1", ps2_d_tx);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({ps2_clk_tx, ps2_d_tx, tx_ready, tx_busy} !== 4'b0010)
      $display("FAIL rst_async got %b want 0010",
               {ps2_clk_tx, ps2_d_tx, tx_ready, tx_busy});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xfer(8'hAA, 1'b0, 11);
    chk_cnt++;
    if ({gd, last_err, stp, par, cap} !== {3'b101, odd_par(8'hAA), 8'hAA})
      $display("FAIL rst_after got %b want %b", {gd, last_err, stp, par, cap},
               {3'b101, odd_par(8'hAA), 8'hAA});
    else pass_cnt++;
  endtask

  task automatic test_held_valid();
    logic [7:0] cp[3];
    int dc0;
    acc_q.delete();
    acc_c.delete();
    fork
      begin
        while (acc_q.size() < 3) begin
          tx_data  = 8'($urandom);
          tx_valid = 1'b1;
          if (tx_ready) begin
            acc_q.push_back(tx_data);
            acc_c.push_back(cyc);
          end
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join_none
    device(1'b0, 11, 1'b1, cp[0], par, stp, hi, rel, gd);
    dc0 = last_dc;
    device(1'b0, 11, 1'b1, cp[1], par, stp, hi, rel, gd);
    device(1'b0, 11, 1'b1, cp[2], par, stp, hi, rel, gd);
    chk_cnt++;
    if (acc_q.size() != 3) begin
      $display("FAIL held_accepts got %0d want 3", acc_q.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        chk_cnt++;
        if (cp[i] !== acc_q[i])
          $display("FAIL held_byte%0d got %02h want %02h", i, cp[i], acc_q[i]);
        else pass_cnt++;
      end
      chk_cnt++;
      if (acc_c[1] !== dc0 + 1)
        $display("FAIL held_next got %0d want %0d", acc_c[1], dc0 + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit n;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      n = 1'($urandom_range(0, 1));
      xfer(b, n, 11);
      chk_cnt++;
      if ({stp, par, cap} !== {1'b1, odd_par(b), b})
        $display("FAIL rand_frame_%02h got %b want %b", b,
                 {stp, par, cap}, {1'b1, odd_par(b), b});
      else pass_cnt++;
      chk_cnt++;
      if ({gd, last_err, last_code} !== {1'b1, n, 1'b0, n})
        $display("FAIL rand_done_%02h got %b want %b", b,
                 {gd, last_err, last_code}, {1'b1, n, 1'b0, n});
      else pass_cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    dev_clk_low = 1'b0;
    dev_d_low   = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_f4();
    test_parity();
    test_nak();
    test_timeout();
    test_reset_mid();
    test_held_valid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
